// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: round-robin IF/DM arbiter and access sequencer
// for the shared single-port 1024 x 64 Y86 data memory.
module y86_mem_arbiter #(
  parameter int DW         = 64,
  parameter int AW         = 10,
  parameter int ADDR_LIMIT = 1024,
  parameter int MEM_LAT    = 2
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [DW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [DW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [DW-1:0] LIMIT    = DW'(ADDR_LIMIT);
  localparam logic [3:0]    CNT_INIT = 4'(MEM_LAT - 1);

  state_t        state;
  logic          last_gnt;
  logic          gnt;
  logic [3:0]    cnt;
  logic          pick_dm;
  logic          sel_we;
  logic          sel_bad;
  logic [DW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] rd_val;

  // Arbitration pick (last_gnt/gnt: 1 = DM) and address check
  always_comb begin
    pick_dm   = dm_req && (!if_req || !last_gnt);
    sel_addr  = pick_dm ? dm_addr : if_addr;
    sel_we    = pick_dm && dm_we;
    sel_wdata = pick_dm ? dm_wdata : '0;
    sel_bad   = (sel_addr >= LIMIT);
    rd_val    = mem_we ? '0 : mem_rdata;
  end

  assign busy = (state != IDLE);

  // Sequencer: grant, hold mem_en MEM_LAT cycles, pulse ack
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b0;
      gnt       <= 1'b0;
      cnt       <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            gnt      <= pick_dm;
            last_gnt <= pick_dm;
            if (sel_bad) begin
              state <= RESP;
              if (pick_dm) begin
                dm_ack   <= 1'b1;
                dm_err   <= 1'b1;
                dm_rdata <= '0;
              end else begin
                if_ack   <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end
            end else begin
              state     <= ACCESS;
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= sel_addr[AW-1:0];
              mem_wdata <= sel_wdata;
              cnt       <= CNT_INIT;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= RESP;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (gnt) begin
              dm_ack   <= 1'b1;
              dm_rdata <= rd_val;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= rd_val;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          if_ack <= 1'b0;
          if_err <= 1'b0;
          dm_ack <= 1'b0;
          dm_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb_y86_mem_arbiter: directed bench for the IF/DM memory arbiter
// with a behavioural single-port memory model.
module tb_y86_mem_arbiter;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_ack;
  logic [63:0] if_rdata;
  logic        if_err;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [63:0] dm_addr = '0;
  logic [63:0] dm_wdata = '0;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        busy;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int en_cnt = 0;
  int we_cnt = 0;
  int both_cnt = 0;

  logic [63:0] mem [0:1023];

  always #5 clock = ~clock;

  y86_mem_arbiter dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Single-port memory: combinational read, clocked write
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Strobe activity counters sampled mid-cycle
  always @(negedge clock) begin
    if (mem_en) en_cnt++;
    if (mem_en && mem_we) we_cnt++;
    if (if_ack && dm_ack) both_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // sel: 0 = IF ack, 1 = DM ack, 2 = either; n = 0 on timeout
  task automatic wait_ack(input int sel, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    for (int k = 1; k <= 20 && !hit; k++) begin
      step();
      if ((sel == 0 && if_ack) || (sel == 1 && dm_ack) ||
          (sel == 2 && (if_ack || dm_ack))) begin
        n = k;
        hit = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cmp_cnt++;
    if ({if_ack, dm_ack, if_err, dm_err, mem_en, mem_we, busy} !== 7'b0) begin
      err_cnt++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {if_ack, dm_ack, if_err, dm_err, mem_en, mem_we, busy});
    end
    cmp_cnt++;
    if ({if_rdata, dm_rdata, mem_wdata, mem_addr} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: got %h %h %h %h want 0",
               if_rdata, dm_rdata, mem_wdata, mem_addr);
    end
    @(negedge clock);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_if_read();
    int n;
    int e0;
    e0 = en_cnt;
    if_addr = 64'd7;
    if_req = 1'b1;
    step();
    cmp_cnt++;
    if ({mem_en, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 10'd7, 1'b1}) begin
      err_cnt++;
      $display("FAIL if_rd_access: got en=%b we=%b a=%0d busy=%b want 1 0 7 1",
               mem_en, mem_we, mem_addr, busy);
    end
    wait_ack(0, n);
    if_req = 1'b0;
    cmp_cnt++;
    if (n !== 2) begin
      err_cnt++;
      $display("FAIL if_rd_latency: got %0d more cycles want 2", n);
    end
    cmp_cnt++;
    if ({if_rdata, if_err, dm_ack, mem_en} !== {64'd7, 1'b0, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL if_rd_resp: got d=%h err=%b dmack=%b en=%b want 7 0 0 0",
               if_rdata, if_err, dm_ack, mem_en);
    end
    step();
    cmp_cnt++;
    if ({if_ack, busy} !== 2'b00) begin
      err_cnt++;
      $display("FAIL if_rd_pulse: got ack=%b busy=%b want 0 0", if_ack, busy);
    end
    cmp_cnt++;
    if (en_cnt - e0 !== 2) begin
      err_cnt++;
      $display("FAIL if_rd_en_cycles: got %0d want 2", en_cnt - e0);
    end
  endtask

  task automatic test_dm_write_read();
    int n;
    int w0;
    w0 = we_cnt;
    dm_addr = 64'd12;
    dm_wdata = 64'hDEAD_BEEF;
    dm_we = 1'b1;
    dm_req = 1'b1;
    wait_ack(1, n);
    dm_req = 1'b0;
    cmp_cnt++;
    if (n !== 3 || dm_rdata !== 64'd0 || dm_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL dm_wr_ack: got n=%0d d=%h err=%b want 3 0 0",
               n, dm_rdata, dm_err);
    end
    step();
    cmp_cnt++;
    if (we_cnt - w0 !== 2) begin
      err_cnt++;
      $display("FAIL dm_wr_we_cycles: got %0d want 2", we_cnt - w0);
    end
    dm_we = 1'b0;
    dm_wdata = 64'h1111;
    dm_req = 1'b1;
    wait_ack(1, n);
    dm_req = 1'b0;
    cmp_cnt++;
    if (n !== 3 || dm_rdata !== 64'hDEAD_BEEF || if_ack !== 1'b0) begin
      err_cnt++;
      $display("FAIL dm_rd_ack: got n=%0d d=%h ifack=%b want 3 deadbeef 0",
               n, dm_rdata, if_ack);
    end
    step();
    step();
    cmp_cnt++;
    if (dm_rdata !== 64'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL dm_rdata_hold: got %h want deadbeef", dm_rdata);
    end
  endtask

  task automatic test_tie();
    logic [1:0] got [1:15];
    int b0;
    logic [63:0] if_d7;
    logic [63:0] dm_d3;
    do_reset();
    b0 = both_cnt;
    if_addr = 64'd7;
    dm_addr = 64'd12;
    dm_we = 1'b0;
    if_req = 1'b1;
    dm_req = 1'b1;
    if_d7 = '0;
    dm_d3 = '0;
    for (int k = 1; k <= 15; k++) begin
      step();
      got[k] = {dm_ack, if_ack};
      if (k == 3) dm_d3 = dm_rdata;
      if (k == 7) if_d7 = if_rdata;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    cmp_cnt++;
    if (got[3] !== 2'b10 || got[7] !== 2'b01 ||
        got[11] !== 2'b10 || got[15] !== 2'b01) begin
      err_cnt++;
      $display("FAIL tie_order: got %b %b %b %b want 10 01 10 01",
               got[3], got[7], got[11], got[15]);
    end
    cmp_cnt++;
    if (got[1] !== 2'b00 || got[2] !== 2'b00 || got[4] !== 2'b00 ||
        got[5] !== 2'b00 || got[6] !== 2'b00 || got[8] !== 2'b00 ||
        got[12] !== 2'b00) begin
      err_cnt++;
      $display("FAIL tie_spacing: stray ack outside steps 3/7/11/15");
    end
    cmp_cnt++;
    if (dm_d3 !== 64'hDEAD_BEEF || if_d7 !== 64'd7) begin
      err_cnt++;
      $display("FAIL tie_data: got dm=%h if=%h want deadbeef 7", dm_d3, if_d7);
    end
    step();
    step();
    cmp_cnt++;
    if (both_cnt - b0 !== 0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL tie_both_acks: got both=%0d busy=%b want 0 0",
               both_cnt - b0, busy);
    end
  endtask

  task automatic test_bad_addr();
    int n;
    int e0;
    e0 = en_cnt;
    dm_addr = 64'd1024;
    dm_we = 1'b1;
    dm_wdata = 64'h5555;
    dm_req = 1'b1;
    wait_ack(1, n);
    dm_req = 1'b0;
    cmp_cnt++;
    if (n !== 1 || dm_err !== 1'b1 || dm_rdata !== 64'd0) begin
      err_cnt++;
      $display("FAIL bad_dm: got n=%0d err=%b d=%h want 1 1 0",
               n, dm_err, dm_rdata);
    end
    cmp_cnt++;
    if (if_ack !== 1'b0 || if_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL bad_dm_other: got ifack=%b iferr=%b want 0 0",
               if_ack, if_err);
    end
    step();
    cmp_cnt++;
    if (dm_err !== 1'b0 || en_cnt - e0 !== 0) begin
      err_cnt++;
      $display("FAIL bad_dm_noen: got err=%b en=%0d want 0 0",
               dm_err, en_cnt - e0);
    end
    if_addr = 64'hFFFF_FFFF_FFFF_0000;
    if_req = 1'b1;
    wait_ack(0, n);
    if_req = 1'b0;
    cmp_cnt++;
    if (n !== 1 || if_err !== 1'b1 || if_rdata !== 64'd0) begin
      err_cnt++;
      $display("FAIL bad_if: got n=%0d err=%b d=%h want 1 1 0",
               n, if_err, if_rdata);
    end
    step();
    cmp_cnt++;
    if (en_cnt - e0 !== 0) begin
      err_cnt++;
      $display("FAIL bad_if_noen: got %0d want 0", en_cnt - e0);
    end
  endtask

  task automatic test_withdraw();
    int n;
    if_addr = 64'd7;
    if_req = 1'b1;
    step();
    if_req = 1'b0;
    if_addr = 64'd12;
    wait_ack(0, n);
    cmp_cnt++;
    if (n !== 2 || if_rdata !== 64'd7 || if_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL withdraw: got n=%0d d=%h err=%b want 2 7 0",
               n, if_rdata, if_err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    int acks;
    dm_addr = 64'd12;
    dm_we = 1'b0;
    dm_req = 1'b1;
    wait_ack(1, n);
    dm_req = 1'b0;
    step();
    if_addr = 64'd7;
    if_req = 1'b1;
    step();
    cmp_cnt++;
    if (mem_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_setup: got en=%b want 1", mem_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({mem_en, busy, if_ack, dm_ack} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL mid_async: got en/busy/ack %b want 0000",
               {mem_en, busy, if_ack, dm_ack});
    end
    if_req = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (if_ack || dm_ack || busy) acks++;
    end
    cmp_cnt++;
    if (acks !== 0) begin
      err_cnt++;
      $display("FAIL mid_noack: got %0d active cycles want 0", acks);
    end
    if_req = 1'b1;
    dm_req = 1'b1;
    wait_ack(2, n);
    if_req = 1'b0;
    dm_req = 1'b0;
    cmp_cnt++;
    if (n !== 3 || dm_ack !== 1'b1 || if_ack !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_tie: got n=%0d dm=%b if=%b want 3 1 0",
               n, dm_ack, if_ack);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[7] = 64'd7;
    test_reset();
    test_if_read();
    test_dm_write_read();
    test_tie();
    test_bad_addr();
    test_withdraw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
